// File: rtl/storage_pkg.sv
// Shared constants and FSM state encoding for the 4 x 8-bit storage system.
// Contents: DATA_W/ADDR_W/DEPTH storage geometry and the read-sequencer state enum.
package storage_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAP,
    SEND,
    FIN
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Loadable modulo-DEPTH address counter with a decrementing remaining-count.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_load       - load i_addr and clamped i_count
//   i_addr       - first address of the burst
//   i_count      - requested word count (clamped to DEPTH on load)
//   i_step       - advance to the next address, one fewer word remaining
//   o_addr       - current address (registered)
//   o_is_last    - exactly one word remains (registered)
module wrap_counter #(
  parameter int unsigned ADDR_W = storage_pkg::ADDR_W,
  parameter int unsigned DEPTH  = storage_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W:0]   i_count,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_is_last
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_is_last;

  logic [CNT_W-1:0]  w_eff_count;
  logic [ADDR_W-1:0] w_next_addr;

  // Requests larger than the storage read every word exactly once.
  assign w_eff_count = (i_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_count;

  // Explicit wrap keeps the counter correct even for non-power-of-two depths.
  assign w_next_addr = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);

  // Address/remaining state; is_last is precomputed so it is a clean register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_is_last   <= 1'b0;
    end else if (i_load) begin
      r_addr      <= i_addr;
      r_remaining <= w_eff_count;
      r_is_last   <= (w_eff_count == CNT_W'(1));
    end else if (i_step) begin
      r_addr      <= w_next_addr;
      r_remaining <= r_remaining - CNT_W'(1);
      r_is_last   <= (r_remaining == CNT_W'(2));
    end
  end

  assign o_addr    = r_addr;
  assign o_is_last = r_is_last;

endmodule

// File: rtl/storage_reader.sv
// Read-side sequencer: walks a wrap-around address range of the storage and
// streams each fetched word over a valid/ready handshake.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - begin a burst (sampled in IDLE only)
//   start_addr   - first address, sampled with start
//   count        - words to read (clamped to DEPTH), sampled with start
//   mem_addr     - address to the storage read port (registered)
//   mem_q        - storage read data, valid the cycle after mem_addr changes
//   m_data       - streamed word (registered)
//   m_valid      - m_data valid (registered)
//   m_ready      - consumer accepts the word
//   busy         - FSM not in IDLE (registered)
//   done         - one-cycle end-of-burst pulse (registered)
module storage_reader #(
  parameter int unsigned DATA_W = storage_pkg::DATA_W,
  parameter int unsigned ADDR_W = storage_pkg::ADDR_W,
  parameter int unsigned DEPTH  = storage_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  import storage_pkg::*;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_step;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr;
  logic              w_is_last;

  assign w_xfer = (r_state == SEND) && r_valid && m_ready;

  // Empty bursts never touch the counter, so mem_addr keeps its last value.
  assign w_load = (r_state == IDLE) && start && (count != '0);

  // The final handshake does not step, leaving mem_addr on the last word read.
  assign w_step = w_xfer && !w_is_last;

  wrap_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wrap_counter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_addr    (start_addr),
    .i_count   (count),
    .i_step    (w_step),
    .o_addr    (w_addr),
    .o_is_last (w_is_last)
  );

  // Burst FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (count == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ADDR;
            end
          end
        end
        ADDR: r_state <= CAP;
        CAP: begin
          r_data  <= mem_q;
          r_valid <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            if (w_is_last) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ADDR;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = w_addr;
  assign m_data   = r_data;
  assign m_valid  = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_storage_reader.sv
// Self-checking bench for storage_reader with a behavioural storage model.
module tb_storage_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] start_addr;
  logic [2:0] count;
  logic [1:0] mem_addr;
  logic [7:0] mem_q;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;

  // Storage model: synchronous write, registered read
  logic [7:0] mem [4];
  logic       wr;
  logic [1:0] wr_addr;
  logic [7:0] wr_d;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr) mem[wr_addr] <= wr_d;
    mem_q <= mem[mem_addr];
  end

  storage_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [1:0] sa;
    logic [2:0] cnt;
    int         n;
    logic [7:0] w0, w1, w2, w3;
    int         done_k;
    bit         poke;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic write_word(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; wr_addr = a; wr_d = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Cycle k means the cycle after the k-th edge following the start edge.
  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] exp_w [4];
    int words, dones, done_at;
    exp_w[0] = v.w0; exp_w[1] = v.w1; exp_w[2] = v.w2; exp_w[3] = v.w3;
    words = 0; dones = 0; done_at = -1;
    m_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; start_addr = v.sa; count = v.cnt;
    @(negedge clk);
    start = 1'b0; start_addr = 2'd0; count = 3'd0;
    for (int k = 1; k <= v.done_k + 3; k++) begin
      if (k > 1) @(negedge clk);
      if (m_valid) begin
        if (words < 4) check($sformatf("v%0d_data%0d", idx, words), int'(m_data), int'(exp_w[words]));
        check($sformatf("v%0d_vcyc%0d", idx, words), k, 3 * words + 3);
        words++;
      end
      if (v.n > 0 && (k % 3) == 1 && ((k - 1) / 3) < v.n)
        check($sformatf("v%0d_addr_k%0d", idx, k), int'(mem_addr), (int'(v.sa) + (k - 1) / 3) % 4);
      if (done) begin dones++; done_at = k; end
      if (k == v.done_k)     check($sformatf("v%0d_busy_hi", idx), int'(busy), 1);
      if (k == v.done_k + 1) check($sformatf("v%0d_busy_lo", idx), int'(busy), 0);
      // Mid-burst start with different args must be ignored
      if (v.poke && k == 4) begin start = 1'b1; start_addr = 2'd2; count = 3'd1; end
      else if (v.poke && k == 5) begin start = 1'b0; start_addr = 2'd0; count = 3'd0; end
    end
    check($sformatf("v%0d_nwords", idx), words, v.n);
    check($sformatf("v%0d_ndone", idx), dones, 1);
    check($sformatf("v%0d_done_k", idx), done_at, v.done_k);
  endtask

  initial begin
    int t, dones;

    vecs[0] = '{2'd0, 3'd4, 4, 8'h11, 8'h22, 8'h33, 8'h44, 13, 1'b0};
    vecs[1] = '{2'd3, 3'd3, 3, 8'h44, 8'h11, 8'h22, 8'h00, 10, 1'b0};
    vecs[2] = '{2'd0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1,  1'b0};
    vecs[3] = '{2'd1, 3'd7, 4, 8'h22, 8'h33, 8'h44, 8'h11, 13, 1'b0};
    vecs[4] = '{2'd2, 3'd1, 1, 8'h33, 8'h00, 8'h00, 8'h00, 4,  1'b0};
    vecs[5] = '{2'd2, 3'd5, 4, 8'h33, 8'h44, 8'h11, 8'h22, 13, 1'b0};
    vecs[6] = '{2'd0, 3'd4, 4, 8'h11, 8'h22, 8'h33, 8'h44, 13, 1'b1};

    rst = 1'b1; start = 1'b0; start_addr = 2'd0; count = 3'd0; m_ready = 1'b1;
    wr = 1'b0; wr_addr = 2'd0; wr_d = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_data", int'(m_data), 0);
    rst = 1'b0;

    write_word(2'd0, 8'h11);
    write_word(2'd1, 8'h22);
    write_word(2'd2, 8'h33);
    write_word(2'd3, 8'h44);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Backpressure: first word held for 5 cycles, then one transfer
    m_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = 2'd0; count = 3'd2;
    @(negedge clk);
    start = 1'b0;
    for (t = 0; t < 10 && !m_valid; t++) @(negedge clk);
    check("bp_first_valid", int'(m_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid%0d", i), int'(m_valid), 1);
      check($sformatf("bp_hold_data%0d", i), int'(m_data), 8'h11);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_after_xfer_valid", int'(m_valid), 0);
    for (t = 0; t < 10 && !m_valid; t++) @(negedge clk);
    check("bp_second_valid", int'(m_valid), 1);
    check("bp_second_data", int'(m_data), 8'h22);
    @(negedge clk);
    check("bp_second_drop", int'(m_valid), 0);
    for (t = 0; t < 10 && !done; t++) @(negedge clk);
    check("bp_done", int'(done), 1);
    @(negedge clk);

    // Reset during the second SEND cycle
    @(negedge clk);
    start = 1'b1; start_addr = 2'd0; count = 3'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rm_second_send_valid", int'(m_valid), 1);
    check("rm_second_send_data", int'(m_data), 8'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rm_valid", int'(m_valid), 0);
    check("rm_busy", int'(busy), 0);
    check("rm_addr", int'(mem_addr), 0);
    dones = int'(done);
    repeat (6) begin
      @(negedge clk);
      dones += int'(done);
    end
    check("rm_no_done", dones, 0);
    run_vec(7, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/storage_reader.md
# storage_reader

Read-side sequencer for the 4 x 8-bit data storage system. On a start pulse it walks a contiguous, wrap-around range of storage addresses, fetches each word through the storage's address/q port, and streams the words out one at a time over a valid/ready handshake. It sits beside the storage `TOP` as the consumer-facing end, while the existing write path (`wr`/`d`/`addr`) fills the storage.

## Interface
- `DATA_W`, default 8: storage word width.
- `ADDR_W`, default 2: storage address width.
- `DEPTH`, default 4: number of storage words, equal to 2**ADDR_W.
- `clk` input, 1 bit: single clock; all logic runs on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: begin a read burst; sampled only in IDLE.
- `start_addr` input, ADDR_W bits: first address of the burst; sampled with `start`.
- `count` input, ADDR_W+1 bits: number of words to read; sampled with `start`.
- `mem_addr` output, ADDR_W bits: address driven to the storage `addr` port.
- `mem_q` input, DATA_W bits: storage read data. It is valid in the cycle after `mem_addr` changes.
- `m_data` output, DATA_W bits: streamed word.
- `m_valid` output, 1 bit: `m_data` is valid.
- `m_ready` input, 1 bit: the consumer accepts the word.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.
- `done` output, 1 bit: one-cycle pulse marking the end of a burst.

## Operation
- FSM states:
  - IDLE
  - ADDR: `mem_addr` is presented.
  - CAP: `m_data` is loaded from `mem_q`.
  - SEND: `m_valid`=1.
  - FIN: `done`=1.
- IDLE → ADDR when `start`=1 and the effective count is ≥1. The block latches `cur_addr`=`start_addr` and `remaining`=effective count.
- Effective count is `count` clamped to DEPTH, so `count`>DEPTH reads DEPTH words.
- IDLE → FIN when `start`=1 and `count`=0. The burst is empty: `done` pulses and no word is sent.
- ADDR → CAP unconditionally. CAP → SEND unconditionally.
- SEND leaves only on the cycle where `m_valid`&&`m_ready`:
  - If `remaining`>1: go to ADDR, with `cur_addr` += 1 modulo DEPTH (wraps 3→0) and `remaining` -= 1.
  - If `remaining`=1: go to FIN.
- FIN → IDLE unconditionally.
- While in SEND, `m_data` is held stable until the word is accepted.
- `start` is ignored in every state except IDLE. `start_addr` and `count` are don't-care outside the sampling cycle.
- The block never drives `wr`. The system rule is that no storage writes occur while `busy`=1; if one does occur, the block returns whatever `mem_q` shows in CAP.
- Reset values:
  - State IDLE; `busy`=0, `done`=0, `m_valid`=0.
  - `m_data`=0, `mem_addr`=0, `remaining`=0.
- `rst` mid-burst: at the next edge the block is in IDLE with all outputs at reset values. No `done` pulse is issued for the aborted burst.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `start` sampled at edge N:
  - `mem_addr` = `start_addr` and `busy`=1 from cycle N+1.
  - `m_data` is captured at edge N+2.
  - `m_valid`=1 from cycle N+3.
- Per word, with `m_ready` held at 1: the handshake occurs in the first SEND cycle. The next `mem_addr` appears in the following cycle, giving one word every 3 cycles.
- `done` is high for exactly one cycle, namely the cycle after the last handshake. `busy` drops in the cycle after `done`.
- For an empty burst (`count`=0): `done` is high in cycle N+1 and `busy`=1 in that same cycle only.
- `mem_addr` holds its last value while in IDLE.

## Structure
- Shared package `storage_pkg` holds:
  - Constants DATA_W=8, ADDR_W=2, DEPTH=4.
  - The FSM state enum (IDLE, ADDR, CAP, SEND, FIN).
- The TOP storage and the write-side logic import the same constants.
- One sub-module is natural: `wrap_counter`. It is a loadable modulo-DEPTH address counter with a decrementing remaining-count and an `is_last` flag.
- Everything else (FSM, output register) lives in `storage_reader`. Target size is roughly 150–250 lines.

## Test plan
- Preload storage 0..3 = 8'h11, 8'h22, 8'h33, 8'h44 through the write path. Pulse `start`, `start_addr`=0, `count`=4, `m_ready`=1 → stream 11, 22, 33, 44, each `m_valid` 3 cycles apart. First `m_valid` at N+3, one `done` pulse after the last word.
- Wrap-around: `start_addr`=3, `count`=3 → `mem_addr` sequence 3, 0, 1; data 44, 11, 22.
- Backpressure: hold `m_ready`=0 for 5 cycles in the first SEND → `m_data`=8'h11 stays stable with `m_valid`=1 throughout. A single transfer occurs when `m_ready` rises, and no word is duplicated or skipped.
- Edge counts:
  - `count`=0 → no `m_valid`, `done` at N+1, `busy` for 1 cycle.
  - `count`=7 → exactly 4 words.
  - A second `start` pulsed mid-burst → ignored.
- Reset mid-burst: assert `rst` during the second SEND → next cycle `m_valid`=0, `busy`=0, `mem_addr`=0, no `done`. A new `start` afterwards yields a correct full burst.
